// File: rtl/ins_main_memory_pkg.sv
// Shared definitions for the instruction-side main memory and its cache refill interface.
// Widths here are also used by ins_cache_memory, so they must stay in step with it.
package ins_main_memory_pkg;

    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_W         = 2;
    localparam int BLOCK_ADDR_W   = 28;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_DONE
    } mem_state_e;

endpackage

// File: rtl/ins_main_memory_if.sv
// Refill bus between the instruction cache (master) and main memory (slave), plus the
// word-wide preload port driven by a bench or bootloader from the master side.
interface ins_main_memory_if
    import ins_main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = BLOCK_ADDR_W
);

    logic                    mem_read;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [LINE_W-1:0]       mem_read_data;
    logic                    mem_busywait;
    logic                    load_en;
    logic [ADDR_WIDTH+1:0]   load_addr;
    logic [WORD_W-1:0]       load_data;

    modport master (
        output mem_read,
        output mem_address,
        output load_en,
        output load_addr,
        output load_data,
        input  mem_read_data,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        input  load_en,
        input  load_addr,
        input  load_data,
        output mem_read_data,
        output mem_busywait
    );

endinterface

// File: rtl/ins_main_memory_word_ram.sv
// Word-organised backing store: asynchronous read for the line assembler, synchronous
// write for the preload port. Contents are deliberately not reset.
module ins_word_ram
    import ins_main_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] words_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            words_q[wr_addr] <= wr_data;
        end
    end

    // A write landing on the word being read this cycle is seen only from the next cycle.
    assign rd_data = words_q[rd_addr];

endmodule

// File: rtl/ins_main_memory.sv
// Instruction main memory: answers a cache block read after a fixed latency, then
// gathers the line from four word beats and presents it for one cycle.
module ins_main_memory
    import ins_main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = BLOCK_ADDR_W,
    parameter int DEPTH_BLOCKS   = 256,
    parameter int ACCESS_LATENCY = 5
) (
    input logic              clock,
    input logic              reset,
    ins_main_memory_if.slave mem
);

    localparam int IDX_W   = $clog2(DEPTH_BLOCKS);
    localparam int WADDR_W = IDX_W + BEAT_W;
    localparam int LAT_W   = (ACCESS_LATENCY < 2) ? 1 : $clog2(ACCESS_LATENCY);
    localparam logic [LAT_W-1:0] LAT_INIT =
        (ACCESS_LATENCY == 0) ? '0 : LAT_W'(ACCESS_LATENCY - 1);

    mem_state_e          state_q, state_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WORD_W-1:0]   rd_word;
    logic                unused_hi_bits;

    ins_word_ram #(
        .DEPTH_WORDS (DEPTH_BLOCKS * BEATS_PER_LINE),
        .ADDR_W      (WADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (mem.load_en),
        .wr_addr (mem.load_addr[WADDR_W-1:0]),
        .wr_data (mem.load_data),
        .rd_addr ({addr_q, beat_q}),
        .rd_data (rd_word)
    );

    // Address bits above the storage index alias onto the same lines.
    assign unused_hi_bits = ^{mem.mem_address[ADDR_WIDTH-1:IDX_W],
                              mem.load_addr[ADDR_WIDTH+1:WADDR_W]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        line_d    = line_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem.mem_read) begin
                    addr_d = mem.mem_address[IDX_W-1:0];
                    beat_d = '0;
                    if (ACCESS_LATENCY == 0) begin
                        state_d = S_FETCH;
                    end else begin
                        lat_cnt_d = LAT_INIT;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!mem.mem_read) begin
                    state_d = S_IDLE;
                end else if (lat_cnt_q == '0) begin
                    beat_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            S_FETCH: begin
                // An abandoned request leaves whatever beats were already gathered.
                if (!mem.mem_read) begin
                    state_d = S_IDLE;
                end else begin
                    line_d[WORD_W*int'(beat_q) +: WORD_W] = rd_word;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational so the cache stalls in the very cycle it raises mem_read.
    assign mem.mem_busywait  = mem.mem_read & (state_q != S_DONE) & ~reset;
    assign mem.mem_read_data = line_q;

endmodule
